// File: rtl/coord_interp.sv
// Linear interpolator: emits N+1 evenly spaced signed points from A to B,
// with fixed-point accumulation (4 fractional bits) and a valid/ready output.
module coord_interp (
  input  logic              CLK,
  input  logic              RST_ASYNC_N,
  input  logic              START,
  input  logic signed [7:0] COORD_A,
  input  logic signed [7:0] COORD_B,
  input  logic [1:0]        STEP_LOG2,
  input  logic              OUT_READY,
  output logic              OUT_VALID,
  output logic signed [7:0] OUT_COORD,
  output logic              OUT_LAST,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, FINISH} state_t;

  state_t             state_q, state_d;
  logic signed [7:0]  a_q, a_d, b_q, b_d;
  logic [1:0]         step_q, step_d;
  logic signed [12:0] acc_q, acc_d, inc_q, inc_d;
  logic [4:0]         index_q, index_d;

  logic [4:0]         lastIndex;
  logic               handshake;
  logic signed [8:0]  delta;
  logic signed [12:0] rounded;
  logic               unusedRoundBits;

  assign lastIndex       = 5'd2 << step_q;
  assign handshake       = (state_q == EMIT) && OUT_READY;
  assign delta           = {b_q[7], b_q} - {a_q[7], a_q};
  assign rounded         = acc_q + 13'sd8;
  assign unusedRoundBits = ^{rounded[12], rounded[3:0]};

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = LOAD;
      LOAD:    state_d = EMIT;
      EMIT:    if (handshake && (index_q == lastIndex)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    OUT_VALID = (state_q == EMIT);
    OUT_LAST  = (state_q == EMIT) && (index_q == lastIndex);
    BUSY      = (state_q != IDLE);
    DONE      = (state_q == FINISH);
    OUT_COORD = rounded[11:4];
  end

  // inc = delta * 16 / N, so N increments land exactly on B << 4.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    step_d  = step_q;
    acc_d   = acc_q;
    inc_d   = inc_q;
    index_d = index_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          a_d    = COORD_A;
          b_d    = COORD_B;
          step_d = STEP_LOG2;
        end
      end
      LOAD: begin
        acc_d   = {a_q[7], a_q, 4'b0000};
        inc_d   = {{4{delta[8]}}, delta} << (2'd3 - step_q);
        index_d = 5'd0;
      end
      EMIT: begin
        if (handshake && (index_q != lastIndex)) begin
          acc_d   = acc_q + inc_q;
          index_d = index_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      a_q     <= '0;
      b_q     <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      inc_q   <= '0;
      index_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      index_q <= index_d;
    end
  end

endmodule

// File: tb/tb_coord_interp.sv
// Randomized self-checking bench for coord_interp; expected points come from
// rounding A + i*(B-A)/N (half up) computed with plain integer arithmetic.
module tb_coord_interp;

  logic              CLK = 1'b0;
  logic              RST_ASYNC_N;
  logic              START;
  logic signed [7:0] COORD_A, COORD_B;
  logic [1:0]        STEP_LOG2;
  logic              OUT_READY;
  logic              OUT_VALID;
  logic signed [7:0] OUT_COORD;
  logic              OUT_LAST;
  logic              BUSY;
  logic              DONE;

  int checks = 0;
  int errors = 0;

  coord_interp dut (
    .CLK        (CLK),
    .RST_ASYNC_N(RST_ASYNC_N),
    .START      (START),
    .COORD_A    (COORD_A),
    .COORD_B    (COORD_B),
    .STEP_LOG2  (STEP_LOG2),
    .OUT_READY  (OUT_READY),
    .OUT_VALID  (OUT_VALID),
    .OUT_COORD  (OUT_COORD),
    .OUT_LAST   (OUT_LAST),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Point i is A + i*(B-A)/N rounded half up; scaled by 16 to stay in integers.
  function automatic int refPoint(input int a, input int b, input int n, input int i);
    int scaled;
    scaled = 16 * a + (i * 16 * (b - a)) / n;
    return (scaled + 8) >>> 4;
  endfunction

  function automatic logic readyBit(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc - 1) % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic applyStimulus(input int a, input int b, input int step,
                               input int readyMode, input bit restart);
    int n, idx, cycles;
    int expected[$];
    bit firstObs;
    n = 2 << step;
    for (int i = 0; i <= n; i++) expected.push_back(refPoint(a, b, n, i));

    COORD_A   = a[7:0];
    COORD_B   = b[7:0];
    STEP_LOG2 = step[1:0];
    START     = 1'b1;
    @(posedge CLK); #1;
    START     = 1'b0;
    COORD_A   = 8'($urandom);
    COORD_B   = 8'($urandom);
    STEP_LOG2 = 2'($urandom);
    checkOutput("load_valid", OUT_VALID, 0);
    checkOutput("load_busy", BUSY, 1);

    idx = 0;
    cycles = 0;
    firstObs = 1'b1;
    while (idx <= n && cycles < 200) begin
      @(posedge CLK); #1;
      cycles++;
      if (firstObs) begin
        checkOutput("latency_valid", OUT_VALID, 1);
        firstObs = 1'b0;
      end
      if (!OUT_VALID) begin
        checkOutput("emit_valid", OUT_VALID, 1);
        break;
      end
      checkOutput("coord", int'(OUT_COORD), expected[idx]);
      checkOutput("last", OUT_LAST, int'(idx == n));
      checkOutput("emit_done", DONE, 0);
      START     = restart && (idx == 2);
      OUT_READY = readyBit(readyMode, cycles);
      if (OUT_READY) idx++;
    end
    if (cycles >= 200) checkOutput("emit_timeout", idx, n + 1);
    START = 1'b0;

    @(posedge CLK); #1;
    checkOutput("finish_done", DONE, 1);
    checkOutput("finish_valid", OUT_VALID, 0);
    checkOutput("finish_busy", BUSY, 1);
    OUT_READY = 1'($urandom_range(0, 1));
    @(posedge CLK); #1;
    checkOutput("idle_done", DONE, 0);
    checkOutput("idle_busy", BUSY, 0);
    checkOutput("idle_valid", OUT_VALID, 0);
  endtask

  // Abort a run asynchronously while the third point is on the output.
  task automatic resetMidRun(input int a, input int b, input int step);
    int idx, cycles;
    COORD_A   = a[7:0];
    COORD_B   = b[7:0];
    STEP_LOG2 = step[1:0];
    START     = 1'b1;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    idx = 0;
    cycles = 0;
    while (cycles < 50) begin
      @(posedge CLK); #1;
      cycles++;
      if (OUT_VALID && idx == 2) break;
      if (OUT_VALID) idx++;
    end
    checkOutput("third_point", int'(OUT_COORD), refPoint(a, b, 2 << step, 2));
    #2 RST_ASYNC_N = 1'b0;
    #1;
    checkOutput("rst_valid", OUT_VALID, 0);
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_done", DONE, 0);
    checkOutput("rst_last", OUT_LAST, 0);
    checkOutput("rst_coord", int'(OUT_COORD), 0);
    @(negedge CLK);
    RST_ASYNC_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      checkOutput("post_rst_busy", BUSY, 0);
      checkOutput("post_rst_done", DONE, 0);
    end
  endtask

  initial begin
    RST_ASYNC_N = 1'b0;
    START       = 1'b1;
    COORD_A     = 8'sd33;
    COORD_B     = -8'sd7;
    STEP_LOG2   = 2'd2;
    OUT_READY   = 1'b1;
    #1;
    checkOutput("reset_valid", OUT_VALID, 0);
    checkOutput("reset_busy", BUSY, 0);
    checkOutput("reset_done", DONE, 0);
    checkOutput("reset_last", OUT_LAST, 0);
    checkOutput("reset_coord", int'(OUT_COORD), 0);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_hold_busy", BUSY, 0);
    START = 1'b0;
    @(negedge CLK);
    RST_ASYNC_N = 1'b1;
    @(posedge CLK); #1;
    checkOutput("idle_after_reset", BUSY, 0);

    $display("[TB] directed runs");
    applyStimulus(0, 16, 3, 0, 1'b0);
    applyStimulus(-128, 127, 0, 0, 1'b0);
    applyStimulus(20, -20, 1, 1, 1'b0);
    applyStimulus(5, 5, 1, 0, 1'b1);
    applyStimulus(127, -128, 3, 2, 1'b0);

    $display("[TB] reset during run");
    resetMidRun(-40, 90, 2);
    applyStimulus(-40, 90, 2, 0, 1'b0);

    $display("[TB] random runs");
    for (int r = 0; r < 24; r++) begin
      applyStimulus(int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 255)) - 128,
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
